// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-sequence game: state codes, the
// controller output bundle and the state-to-output decode.
package jogo_pkg;

   localparam int N_RODADAS = 16;

   // State codes double as the hex display value, so they are fixed explicitly.
   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h4,
      COMPARA     = 4'h5,
      PROX_JOGADA = 4'h6,
      PROX_RODADA = 4'h7,
      FIM_ACERTO  = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERRO    = 4'hE
   } estado_t;

   typedef struct packed {
      logic zera_e;
      logic conta_e;
      logic zera_r;
      logic conta_r;
      logic registra;
      logic pronto;
      logic ganhou;
      logic perdeu;
      logic db_timeout;
   } saidas_t;

   // Moore decode: the outputs asserted while sitting in a given state.
   function automatic saidas_t decodifica(estado_t e);
      saidas_t s;
      s = '0;
      case (e)
         PREPARA:     begin s.zera_e = 1'b1; s.zera_r = 1'b1; end
         REGISTRA:    s.registra = 1'b1;
         PROX_JOGADA: s.conta_e = 1'b1;
         PROX_RODADA: begin s.conta_r = 1'b1; s.zera_e = 1'b1; end
         FIM_ACERTO:  begin s.pronto = 1'b1; s.ganhou = 1'b1; end
         FIM_ERRO:    begin s.pronto = 1'b1; s.perdeu = 1'b1; end
         FIM_TIMEOUT: begin s.pronto = 1'b1; s.perdeu = 1'b1; s.db_timeout = 1'b1; end
         default:     ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Handshake between the game datapath (master) and the control unit (slave).
interface unidade_controle_jogo_if;

   logic       jogar;
   logic       tem_jogada;
   logic       jogada_correta;
   logic       endereco_igual_rodada;
   logic       rodada_ultima;
   logic       zera_e;
   logic       conta_e;
   logic       zera_r;
   logic       conta_r;
   logic       registra;
   logic       pronto;
   logic       ganhou;
   logic       perdeu;
   logic       db_timeout;
   logic [3:0] db_estado;

   modport master (
      output jogar, tem_jogada, jogada_correta, endereco_igual_rodada, rodada_ultima,
      input  zera_e, conta_e, zera_r, conta_r, registra,
      input  pronto, ganhou, perdeu, db_timeout, db_estado
   );

   modport slave (
      input  jogar, tem_jogada, jogada_correta, endereco_igual_rodada, rodada_ultima,
      output zera_e, conta_e, zera_r, conta_r, registra,
      output pronto, ganhou, perdeu, db_timeout, db_estado
   );

endinterface

// File: rtl/contador_timeout.sv
// Per-play inactivity timer: counts while enabled, cleared otherwise,
// flags the last allowed cycle.
module contador_timeout #(
   parameter int TIMEOUT_CYCLES = 250_000_000,
   parameter int TW             = 28
) (
   input  logic clock,
   input  logic reset,
   input  logic conta,
   input  logic zera,
   output logic fim
);

   logic [TW-1:0] valor;

   // Timer register: clear has priority so every new wait starts from zero.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valor <= '0;
      end else if (zera) begin
         valor <= '0;
      end else if (conta) begin
         valor <= valor + 1'b1;
      end
   end

   assign fim = conta && (valor == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/unidade_controle_jogo.sv
// Control FSM for the memory-sequence game: sequences the play and round
// counters, checks each play and ends the game on win, error or timeout.
module unidade_controle_jogo
   import jogo_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 250_000_000,
   parameter int TW             = 28
) (
   input  logic                    clock,
   input  logic                    reset,
   unidade_controle_jogo_if.slave  bus
);

   estado_t estado;
   estado_t prox;
   saidas_t saidas;
   logic    em_espera;
   logic    fim_timeout;

   assign em_espera = (estado == ESPERA);

   contador_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TW             (TW)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .conta (em_espera),
      .zera  (!em_espera),
      .fim   (fim_timeout)
   );

   // Next-state rules; a press beats a timeout in the same cycle.
   // NOTE: prox gets a default before the case so no latch can be inferred.
   always_comb begin
      prox = INICIAL;
      case (estado)
         INICIAL:     prox = bus.jogar ? PREPARA : INICIAL;
         PREPARA:     prox = ESPERA;
         ESPERA: begin
            if (bus.tem_jogada)    prox = REGISTRA;
            else if (fim_timeout)  prox = FIM_TIMEOUT;
            else                   prox = ESPERA;
         end
         REGISTRA:    prox = COMPARA;
         COMPARA: begin
            if (!bus.jogada_correta)                             prox = FIM_ERRO;
            else if (bus.endereco_igual_rodada && bus.rodada_ultima) prox = FIM_ACERTO;
            else if (bus.endereco_igual_rodada)                  prox = PROX_RODADA;
            else                                                 prox = PROX_JOGADA;
         end
         PROX_JOGADA: prox = ESPERA;
         PROX_RODADA: prox = ESPERA;
         FIM_ACERTO:  prox = bus.jogar ? PREPARA : FIM_ACERTO;
         FIM_ERRO:    prox = bus.jogar ? PREPARA : FIM_ERRO;
         FIM_TIMEOUT: prox = bus.jogar ? PREPARA : FIM_TIMEOUT;
         default:     prox = INICIAL;
      endcase
   end

   // State and output registers; outputs are decoded from the incoming state
   // so they always match the state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= INICIAL;
         saidas <= '0;
      end else begin
         estado <= prox;
         saidas <= decodifica(prox);
      end
   end

   assign bus.zera_e     = saidas.zera_e;
   assign bus.conta_e    = saidas.conta_e;
   assign bus.zera_r     = saidas.zera_r;
   assign bus.conta_r    = saidas.conta_r;
   assign bus.registra   = saidas.registra;
   assign bus.pronto     = saidas.pronto;
   assign bus.ganhou     = saidas.ganhou;
   assign bus.perdeu     = saidas.perdeu;
   assign bus.db_timeout = saidas.db_timeout;
   assign bus.db_estado  = estado;

endmodule
